// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 32-bit timer/compare peripheral. It sits on the
// core data bus in parallel with data_mem and uses the same store signals.
// The top level muxes rdata over the data_mem read data whenever hit=1.
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-high reset
//   d_wr_en  store strobe from the core
//   dAddr    data bus byte address
//   dWdata   store data
//   byte_en  access size: 00 byte, 01 half, 10 word
//   rdata    combinational read data, 0 when not hit
//   hit      dAddr lies inside the 32-byte register window
//   irq      level interrupt, MATCH & IE
//
// Register map (word offsets from BASE_ADDR):
//   0x00 CTRL   {IE, AUTO, EN}
//   0x04 PRESC  prescaler reload value
//   0x08 COUNT  main counter
//   0x0C CMP    compare value
//   0x10 STATUS bit0 MATCH, write 1 to clear
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_wr_en,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic [1:0]  byte_en,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  logic               en, auto_rl, ie, match;
  logic [PRESC_W-1:0] presc, pcnt;
  logic [31:0]        count, cmp;

  logic [2:0] off;
  logic       wr, wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
  logic       tick, at_cmp, match_set;

  assign hit = (dAddr[31:5] == BASE_ADDR[31:5]);
  assign off = dAddr[4:2];

  // Only aligned full-word stores reach the registers.
  assign wr        = d_wr_en && hit && (byte_en == 2'b10) && (dAddr[1:0] == 2'b00);
  assign wr_ctrl   = wr && (off == OFF_CTRL);
  assign wr_presc  = wr && (off == OFF_PRESC);
  assign wr_count  = wr && (off == OFF_COUNT);
  assign wr_cmp    = wr && (off == OFF_CMP);
  assign wr_status = wr && (off == OFF_STATUS);

  // >= rather than == so that lowering PRESC below the running pcnt
  // ticks on the next edge instead of waiting for the counter to wrap.
  assign tick   = en && (pcnt >= presc);
  assign at_cmp = (count == cmp);

  // A COUNT store in a tick cycle suppresses match evaluation entirely.
  assign match_set = tick && at_cmp && !wr_count;

  assign irq = match && ie;

  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (off)
        OFF_CTRL:   rdata = {29'd0, ie, auto_rl, en};
        OFF_PRESC:  rdata = 32'(presc);
        OFF_COUNT:  rdata = count;
        OFF_CMP:    rdata = cmp;
        OFF_STATUS: rdata = {31'd0, match};
        default:    rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
      presc   <= '0;
      pcnt    <= '0;
      count   <= 32'd0;
      cmp     <= 32'hFFFF_FFFF;
      match   <= 1'b0;
    end else begin
      if (!en || tick) pcnt <= '0;
      else             pcnt <= pcnt + 1'b1;

      if (wr_count) begin
        count <= dWdata;
      end else if (tick) begin
        if (!at_cmp)      count <= count + 32'd1;
        else if (auto_rl) count <= 32'd0;
      end

      // CPU write to CTRL beats the one-shot EN clear.
      if (wr_ctrl) begin
        en      <= dWdata[0];
        auto_rl <= dWdata[1];
        ie      <= dWdata[2];
      end else if (match_set && !auto_rl) begin
        en <= 1'b0;
      end

      if (wr_presc) presc <= dWdata[PRESC_W-1:0];
      if (wr_cmp)   cmp   <= dWdata;

      // Set beats a simultaneous write-1-to-clear.
      if (match_set)                   match <= 1'b1;
      else if (wr_status && dWdata[0]) match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer. Inputs change on the falling edge, the
// DUT registers on the rising edge, and outputs are sampled on/after the
// falling edge.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_PRESC  = BASE + 32'h04;
  localparam logic [31:0] A_COUNT  = BASE + 32'h08;
  localparam logic [31:0] A_CMP    = BASE + 32'h0C;
  localparam logic [31:0] A_STATUS = BASE + 32'h10;

  logic        clk, reset, d_wr_en, hit, irq;
  logic [31:0] dAddr, dWdata, rdata;
  logic [1:0]  byte_en;

  int total  = 0;
  int passed = 0;

  mmio_timer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
    .clk(clk), .reset(reset), .d_wr_en(d_wr_en), .dAddr(dAddr),
    .dWdata(dWdata), .byte_en(byte_en), .rdata(rdata), .hit(hit), .irq(irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One store, spanning exactly one rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] be);
    dAddr = a; dWdata = d; byte_en = be; d_wr_en = 1'b1;
    @(negedge clk);
    d_wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    dAddr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; d_wr_en = 1'b0; dAddr = '0; dWdata = '0; byte_en = 2'b10;
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // 1: reset values and decode
    rd_chk("rst_ctrl",   A_CTRL,   32'h0);
    rd_chk("rst_count",  A_COUNT,  32'h0);
    rd_chk("rst_status", A_STATUS, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("rst_cmp", A_CMP, 32'hFFFF_FFFF);
    chk("hit_cmp", {31'd0, hit}, 32'd1);
    rd_chk("miss_rdata", BASE + 32'h20, 32'h0);
    chk("miss_hit", {31'd0, hit}, 32'd0);
    rd_chk("unused_14", BASE + 32'h14, 32'h0);

    // 2: PRESC=0, auto-reload match with interrupt
    wr(A_PRESC, 32'd0, 2'b10);
    wr(A_CMP,   32'd5, 2'b10);
    wr(A_CTRL,  32'h7, 2'b10);
    rd_chk("t2_count0", A_COUNT, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      rd_chk("t2_step", A_COUNT, 32'(i));
    end
    chk("t2_noirq", {31'd0, irq}, 32'd0);
    cyc(1);
    rd_chk("t2_match", A_STATUS, 32'd1);
    chk("t2_irq", {31'd0, irq}, 32'd1);
    rd_chk("t2_reload", A_COUNT, 32'd0);
    wr(A_STATUS, 32'd1, 2'b10);
    chk("t2_irq_clr", {31'd0, irq}, 32'd0);
    rd_chk("t2_status_clr", A_STATUS, 32'd0);

    // 3: PRESC=3 one-shot, IE=0
    wr(A_CTRL,  32'h0, 2'b10);
    wr(A_COUNT, 32'd0, 2'b10);
    wr(A_PRESC, 32'd3, 2'b10);
    wr(A_CMP,   32'd2, 2'b10);
    wr(A_CTRL,  32'h1, 2'b10);
    cyc(3);  rd_chk("t3_c3",  A_COUNT, 32'd0);
    cyc(1);  rd_chk("t3_c4",  A_COUNT, 32'd1);
    cyc(4);  rd_chk("t3_c8",  A_COUNT, 32'd2);
    cyc(3);  rd_chk("t3_nomatch", A_STATUS, 32'd0);
    cyc(1);  rd_chk("t3_match", A_STATUS, 32'd1);
    rd_chk("t3_en_clr", A_CTRL, 32'd0);
    chk("t3_irq_masked", {31'd0, irq}, 32'd0);
    cyc(8);  rd_chk("t3_hold", A_COUNT, 32'd2);

    // 4: wrap without flag, then match ten counts later
    wr(A_STATUS, 32'd1, 2'b10);
    wr(A_COUNT, 32'hFFFF_FFFE, 2'b10);
    wr(A_CMP,   32'd10, 2'b10);
    wr(A_PRESC, 32'd0, 2'b10);
    wr(A_CTRL,  32'h1, 2'b10);
    cyc(1);  rd_chk("t4_ffff", A_COUNT, 32'hFFFF_FFFF);
    cyc(1);  rd_chk("t4_wrap", A_COUNT, 32'd0);
    rd_chk("t4_wrap_nomatch", A_STATUS, 32'd0);
    cyc(10); rd_chk("t4_c10", A_COUNT, 32'd10);
    rd_chk("t4_pre", A_STATUS, 32'd0);
    cyc(1);  rd_chk("t4_match", A_STATUS, 32'd1);

    // 5: ignored stores, COUNT write during a tick
    wr(A_STATUS, 32'd1, 2'b10);
    wr(A_CTRL, 32'hFF, 2'b00);
    rd_chk("t5_byte", A_CTRL, 32'd0);
    wr(A_CTRL, 32'hFF, 2'b01);
    rd_chk("t5_half", A_CTRL, 32'd0);
    wr(BASE + 32'h02, 32'h7, 2'b10);
    rd_chk("t5_misalign", A_CTRL, 32'd0);
    wr(A_CMP,   32'hFFFF_0000, 2'b10);
    wr(A_COUNT, 32'd0, 2'b10);
    wr(A_CTRL,  32'h3, 2'b10);
    cyc(2);  rd_chk("t5_run", A_COUNT, 32'd2);
    wr(A_COUNT, 32'h1234, 2'b10);
    rd_chk("t5_wr_wins", A_COUNT, 32'h1234);
    cyc(1);  rd_chk("t5_resume", A_COUNT, 32'h1235);

    // 6: W1C in the match cycle, then asynchronous reset
    wr(A_CTRL,  32'h0, 2'b10);
    wr(A_CMP,   32'd3, 2'b10);
    wr(A_COUNT, 32'd0, 2'b10);
    wr(A_CTRL,  32'h7, 2'b10);
    cyc(3);  rd_chk("t6_c3", A_COUNT, 32'd3);
    wr(A_STATUS, 32'd1, 2'b10);
    rd_chk("t6_set_wins", A_STATUS, 32'd1);
    chk("t6_irq", {31'd0, irq}, 32'd1);
    cyc(2);
    #2 reset = 1'b1;
    #1 chk("t6_rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("t6_rst_count", A_COUNT, 32'd0);
    rd_chk("t6_rst_cmp",   A_CMP,   32'hFFFF_FFFF);
    rd_chk("t6_rst_ctrl",  A_CTRL,  32'd0);
    rd_chk("t6_rst_stat",  A_STATUS, 32'd0);
    cyc(1);
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
